// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and queued load results onto the register file write port and tracks busy registers
module regfile_writeback #(
    parameter int Width = 32,
    parameter int Depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [Width-1:0] alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_rd,
    input  logic [Width-1:0] ld_data,
    input  logic             issue_valid,
    input  logic             issue_is_load,
    input  logic [4:0]       issue_rd,
    output logic [31:0]      busy,
    output logic             RegWrite,
    output logic [4:0]       W1,
    output logic [Width-1:0] WD1
);
    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    logic [4:0]       fifo_rd   [Depth];
    logic [Width-1:0] fifo_data [Depth];
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    count;
    logic             push, pop;
    logic [4:0]       sel_rd;
    logic [Width-1:0] sel_data;
    logic             sel_any;
    logic [31:0]      busy_next;

    // ready drops during reset so nothing is accepted while the queue is being discarded
    assign ld_ready = (count < CW'(Depth)) && rst_n;
    assign push     = ld_valid && ld_ready;
    // count before this edge's push, so a load pushed this cycle is never popped this cycle
    assign pop      = !alu_valid && count != '0;
    assign sel_any  = alu_valid || pop;
    assign sel_rd   = alu_valid ? alu_rd : fifo_rd[rp];
    assign sel_data = alu_valid ? alu_data : fifo_data[rp];

    // scoreboard next state: clear on pop, then set on load issue so a same-cycle set wins
    always_comb begin
        busy_next = busy;
        if (pop) busy_next[fifo_rd[rp]] = 1'b0;
        if (issue_valid && issue_is_load) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // queue storage needs no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wp]   <= ld_rd;
            fifo_data[wp] <= ld_data;
        end
    end

    // pointers, occupancy and scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            busy  <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            busy  <= busy_next;
        end
    end

    // registered write port; x0 targets are consumed but never written, address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            W1       <= '0;
            WD1      <= '0;
        end else begin
            RegWrite <= sel_any && sel_rd != 5'd0;
            if (sel_any && sel_rd != 5'd0) begin
                W1  <= sel_rd;
                WD1 <= sel_data;
            end
        end
    end
endmodule
